// File: rtl/producao_pkg.sv
// Shared types and helpers for the bottle/cork production monitor:
// refill FSM states, 7-segment glyphs and binary-to-BCD for the cork stock.
package producao_pkg;

   localparam int DUZIA = 12;

   localparam logic [1:0] EST_OCIOSO   = 2'd0;
   localparam logic [1:0] EST_RECARGA  = 2'd1;
   localparam logic [1:0] EST_ESGOTADO = 2'd2;

   typedef enum logic [1:0] {
      OCIOSO   = EST_OCIOSO,
      RECARGA  = EST_RECARGA,
      ESGOTADO = EST_ESGOTADO
   } estado_t;

   // Segments ordered g..a, active-low; non-decimal codes are blank.
   function automatic logic [6:0] seg7(input logic [3:0] bcd);
      case (bcd)
         4'd0:    return 7'h40;
         4'd1:    return 7'h79;
         4'd2:    return 7'h24;
         4'd3:    return 7'h30;
         4'd4:    return 7'h19;
         4'd5:    return 7'h12;
         4'd6:    return 7'h02;
         4'd7:    return 7'h78;
         4'd8:    return 7'h00;
         4'd9:    return 7'h10;
         default: return 7'h7F;
      endcase
   endfunction

   // Units are derived mod 16: v - 10*tens is below 10, so 4-bit arithmetic is exact.
   function automatic logic [7:0] bin2bcd99(input logic [6:0] v);
      logic [3:0] d;
      d = 4'd0;
      for (int t = 1; t <= 9; t++) begin
         if (v >= 7'(10 * t)) d = 4'(t);
      end
      return {d, v[3:0] - d * 4'd10};
   endfunction

endpackage

// File: rtl/varredura_7seg.sv
// Time-multiplexed common-anode display scanner: owns the digit divider and
// scan index, and registers segments and digit enable together.
module varredura_7seg
   import producao_pkg::*;
#(
   parameter int N_DIG = 4,
   parameter int DIV   = 50000
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [4*N_DIG-1:0]   bcd,
   output logic [6:0]           seg,
   output logic [N_DIG-1:0]     dig
);

   localparam int IW = (N_DIG > 1) ? $clog2(N_DIG) : 1;
   localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [IW-1:0] IDX_ULT = IW'(N_DIG - 1);
   localparam logic [DW-1:0] DIV_ULT = DW'(DIV - 1);

   logic [DW-1:0] cnt;
   logic [IW-1:0] idx;
   logic [IW-1:0] idx_n;

   always_comb begin
      idx_n = idx;
      if (cnt == DIV_ULT) idx_n = (idx == IDX_ULT) ? '0 : idx + IW'(1);
   end

   // Glyph and enable both follow idx_n so they change on the same edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt <= '0;
         idx <= '0;
         dig <= {{(N_DIG-1){1'b1}}, 1'b0};
         seg <= seg7(4'd0);
      end else begin
         cnt <= (cnt == DIV_ULT) ? '0 : cnt + DW'(1);
         idx <= idx_n;
         dig <= ~(N_DIG'(1) << idx_n);
         seg <= seg7(bcd[{idx_n, 2'b00} +: 4]);
      end
   end

endmodule

// File: rtl/monitor_producao_param.sv
// Bottle/cork production monitor: counts sealed bottles in BCD dozens and
// manages cork stock with budget-limited automatic refills.
module monitor_producao_param
   import producao_pkg::*;
#(
   parameter int DIG_GAR   = 2,
   parameter int ROLHA_INI = 25,
   parameter int ROLHA_MIN = 5,
   parameter int REC_MAX   = 7,
   parameter int SCAN_DIV  = 50000
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 garrafa,
   input  logic                 recarga_manual,
   output logic [6:0]           OUT,
   output logic [DIG_GAR+1:0]   dig,
   output logic                 sem_rolha,
   output logic [3:0]           recargas,
   output logic [1:0]           estado
);

   localparam int N_DIG = DIG_GAR + 2;
   localparam logic [6:0] INI7      = 7'(ROLHA_INI);
   localparam logic [6:0] MIN7      = 7'(ROLHA_MIN);
   localparam logic [3:0] MAX4      = 4'(REC_MAX);
   localparam logic [3:0] PRESC_FIM = 4'(DUZIA - 1);

   logic                   garrafa_ant, manual_ant;
   logic                   ev_gar, ev_man, aceita;
   logic [6:0]             estoque, estoque_n, est_menos;
   logic [7:0]             soma;
   logic [3:0]             orcamento, orc_n;
   logic [3:0]             presc, presc_n;
   logic [4*DIG_GAR-1:0]   duzias, duz_n;
   estado_t                est, est_n;
   logic [7:0]             est_bcd;
   logic [4*N_DIG-1:0]     vis;

   assign ev_gar    = garrafa & ~garrafa_ant;
   assign ev_man    = recarga_manual & ~manual_ant;
   assign aceita    = ev_gar && (estoque != 7'd0);
   assign est_menos = estoque - 7'(aceita);

   always_comb begin : contagem
      logic carry;
      presc_n = presc;
      duz_n   = duzias;
      carry   = 1'b0;
      if (aceita) begin
         if (presc == PRESC_FIM) begin
            presc_n = '0;
            carry   = 1'b1;
            for (int i = 0; i < DIG_GAR; i++) begin
               if (carry) begin
                  if (duzias[4*i +: 4] == 4'd9) begin
                     duz_n[4*i +: 4] = 4'd0;
                  end else begin
                     duz_n[4*i +: 4] = duzias[4*i +: 4] + 4'd1;
                     carry = 1'b0;
                  end
               end
            end
         end else begin
            presc_n = presc + 4'd1;
         end
      end
   end

   // The bottle decrement (est_menos) is applied before the refill addition.
   always_comb begin
      estoque_n = est_menos;
      orc_n     = orcamento;
      est_n     = est;
      soma      = {1'b0, est_menos} + {1'b0, INI7};
      if (ev_man && est != ESGOTADO && orcamento != MAX4) orc_n = orcamento + 4'd1;
      case (est)
         OCIOSO: begin
            if (aceita && est_menos == MIN7 && orcamento != 4'd0)
               est_n = RECARGA;
            else if (aceita && est_menos == 7'd0 && orcamento == 4'd0)
               est_n = ESGOTADO;
         end
         RECARGA: begin
            estoque_n = (soma > 8'd99) ? 7'd99 : soma[6:0];
            orc_n     = ev_man ? orcamento : orcamento - 4'd1;
            est_n     = OCIOSO;
         end
         ESGOTADO: begin
            if (ev_man) begin
               estoque_n = INI7;
               est_n     = OCIOSO;
            end
         end
         default: est_n = OCIOSO;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         garrafa_ant <= 1'b0;
         manual_ant  <= 1'b0;
         estoque     <= INI7;
         orcamento   <= MAX4;
         presc       <= '0;
         duzias      <= '0;
         est         <= OCIOSO;
      end else begin
         garrafa_ant <= garrafa;
         manual_ant  <= recarga_manual;
         estoque     <= estoque_n;
         orcamento   <= orc_n;
         presc       <= presc_n;
         duzias      <= duz_n;
         est         <= est_n;
      end
   end

   assign est_bcd = bin2bcd99(estoque);

   // Display index 0 is the most significant dozen digit.
   always_comb begin
      vis = '0;
      for (int k = 0; k < DIG_GAR; k++) vis[4*k +: 4] = duzias[4*(DIG_GAR-1-k) +: 4];
      vis[4*DIG_GAR +: 4]     = est_bcd[7:4];
      vis[4*(DIG_GAR+1) +: 4] = est_bcd[3:0];
   end

   varredura_7seg #(
      .N_DIG (N_DIG),
      .DIV   (SCAN_DIV)
   ) u_varredura (
      .clk (clk),
      .rst (rst),
      .bcd (vis),
      .seg (OUT),
      .dig (dig)
   );

   assign sem_rolha = (est == ESGOTADO);
   assign recargas  = orcamento;
   assign estado    = est;

endmodule
